// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: sequencing controller for a small add/sub/mul/div unit.
// A request walks IDLE -> LOAD -> EXEC -> WRITE -> IDLE. EXEC takes one
// cycle for add/sub and N cycles for mul (shift-add) and div (restoring).
// The result register holds the last completed result together with its
// error flag.
// Build option: define CALC_DIV_EN to build the divider. Without it,
// op=11 finishes after one EXEC cycle with result=0 and err=1.
module calc_seq_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ld_a,
  output logic         ld_b,
  output logic         ld_res,
  output logic         busy,
  output logic         done,
  output logic [2*N-1:0] result,
  output logic         err
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_LONG = CW'(N - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    EXEC  = 2'b10,
    WRITE = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]  prod_q, prod_d;
  logic [2*N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]    mplier_q, mplier_d;
  logic [2*N-1:0]  result_q, result_d;
  logic            err_q, err_d;
`ifdef CALC_DIV_EN
  logic [N:0]      rem_q, rem_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [N:0]      rem_shift;
  logic [N:0]      b_ext;
`endif

  logic [N:0]      sum_w;
  logic [N:0]      diff_w;
  logic            long_op;
  logic [CW-1:0]   last_cnt;
  logic [2*N-1:0]  res_calc;
  logic            err_calc;

  // The diff's top bit is the borrow, so it doubles as the a<b flag.
  assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_w = {1'b0, a_q} - {1'b0, b_q};

`ifdef CALC_DIV_EN
  assign rem_shift = {rem_q[N-1:0], quo_q[N-1]};
  assign b_ext     = {1'b0, b_q};
  assign long_op   = (op_q == OP_MUL) || (op_q == OP_DIV);
`else
  assign long_op   = (op_q == OP_MUL);
`endif

  assign last_cnt = long_op ? LAST_LONG : '0;

  // Final result and error flag for the captured operation, used in WRITE.
  always_comb begin
    res_calc = '0;
    err_calc = 1'b0;
    case (op_q)
      OP_ADD: res_calc = {{(N-1){1'b0}}, sum_w};
      OP_SUB: res_calc = {{(N-1){1'b0}}, diff_w};
      OP_MUL: res_calc = prod_q;
      default: begin
`ifdef CALC_DIV_EN
        res_calc = {rem_q[N-1:0], quo_q};
        err_calc = (b_q == '0);
`else
        res_calc = '0;
        err_calc = 1'b1;
`endif
      end
    endcase
  end

  // Next-state, operand capture and per-cycle mul/div step; reset wins.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    err_d    = err_q;
`ifdef CALC_DIV_EN
    rem_d    = rem_q;
    quo_d    = quo_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          a_d     = a;
          b_d     = b;
          op_d    = op;
        end
      end
      LOAD: begin
        state_d  = EXEC;
        cnt_d    = '0;
        prod_d   = '0;
        mcand_d  = {{N{1'b0}}, a_q};
        mplier_d = b_q;
`ifdef CALC_DIV_EN
        rem_d    = '0;
        quo_d    = a_q;
`endif
      end
      EXEC: begin
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
`ifdef CALC_DIV_EN
        if (rem_shift >= b_ext) begin
          rem_d = rem_shift - b_ext;
          quo_d = {quo_q[N-2:0], 1'b1};
        end else begin
          rem_d = rem_shift;
          quo_d = {quo_q[N-2:0], 1'b0};
        end
`endif
        if (cnt_q == last_cnt) begin
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WRITE: begin
        state_d  = IDLE;
        result_d = res_calc;
        err_d    = err_calc;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d  = IDLE;
      result_d = '0;
      err_d    = 1'b0;
      cnt_d    = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    state_q  <= state_d;
    a_q      <= a_d;
    b_q      <= b_d;
    op_q     <= op_d;
    cnt_q    <= cnt_d;
    prod_q   <= prod_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    result_q <= result_d;
    err_q    <= err_d;
`ifdef CALC_DIV_EN
    rem_q    <= rem_d;
    quo_q    <= quo_d;
`endif
  end

  // Strobes are suppressed while reset is held, so an aborted op shows no done.
  assign ld_a   = (state_q == LOAD)  && !rst;
  assign ld_b   = (state_q == LOAD)  && !rst;
  assign ld_res = (state_q == WRITE) && !rst;
  assign done   = (state_q == WRITE) && !rst;
  assign busy   = (state_q != IDLE);
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed testbench for calc_seq_ctrl (N=8) with a scoreboard queue.
// Honours CALC_DIV_EN the same way the design does.
module tb_calc_seq_ctrl;

  localparam int N = 8;
`ifdef CALC_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ld_a, ld_b, ld_res, busy, done, err;
  logic [2*N-1:0] result;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  calc_seq_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .ld_a(ld_a), .ld_b(ld_b), .ld_res(ld_res), .busy(busy), .done(done),
    .result(result), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: {err, result} for one operation.
  function automatic logic [16:0] model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    logic [16:0] r;
    case (o)
      2'b00:   r = {1'b0, 16'(x) + 16'(y)};
      2'b01:   r = {1'b0, 7'b0, (x < y), 8'(x - y)};
      2'b10:   r = {1'b0, 16'(x) * 16'(y)};
      default: begin
        if (!DIV_EN)      r = {1'b1, 16'h0000};
        else if (y == 0)  r = {1'b1, x, 8'hFF};
        else              r = {1'b0, 8'(x % y), 8'(x / y)};
      end
    endcase
    return r;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) passes++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, expv);
  endtask

  // Drive a request in the current cycle (called just after a falling edge).
  task automatic applyStimulus(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                               input logic [16:0] e);
    exp_t t;
    op = o; a = x; b = y; start = 1'b1;
    t.res = e[15:0];
    t.err = e[16];
    t.lat = (o == 2'b10 || (o == 2'b11 && DIV_EN)) ? 2 + N : 3;
    sb.push_back(t);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Follow one transaction to the first IDLE cycle after WRITE.
  task automatic checkOutput(input int pulse_cyc);
    exp_t t;
    int done_cnt;
    int done_cyc;
    done_cnt = 0;
    done_cyc = 0;
    t = sb.pop_front();
    for (int cyc = 1; cyc <= t.lat + 1; cyc++) begin
      @(negedge clk);
      start = (cyc == pulse_cyc);
      if (cyc == 1) checkValue("ld_ab_load", {30'b0, ld_a, ld_b}, 32'd3);
      if (cyc == 2) begin
        checkValue("ld_ab_exec", {30'b0, ld_a, ld_b}, 32'd0);
        a  = 8'($urandom_range(0, 255));
        b  = 8'($urandom_range(0, 255));
        op = 2'($urandom_range(0, 3));
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        checkValue("ld_res_with_done", {31'b0, ld_res}, 32'd1);
      end
      if (cyc == t.lat + 1) begin
        checkValue("busy_after", {31'b0, busy}, 32'd0);
        checkValue("result", {16'b0, result}, {16'b0, t.res});
        checkValue("err", {31'b0, err}, {31'b0, t.err});
      end
    end
    checkValue("done_count", done_cnt, 1);
    checkValue("done_latency", done_cyc, t.lat);
  endtask

  initial begin
    exp_t scratch;
    int   dcount;
    logic [1:0] ro;
    logic [7:0] ra, rb;

    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checkValue("rst_busy",   {31'b0, busy},   32'd0);
    checkValue("rst_done",   {31'b0, done},   32'd0);
    checkValue("rst_ld",     {29'b0, ld_a, ld_b, ld_res}, 32'd0);
    checkValue("rst_result", {16'b0, result}, 32'd0);
    checkValue("rst_err",    {31'b0, err},    32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] add / sub vectors");
    applyStimulus(2'b00, 8'd200, 8'd100, 17'h0_012C);
    checkOutput(0);
    applyStimulus(2'b01, 8'd5, 8'd7, 17'h0_01FE);
    checkOutput(0);

    $display("[TB] mul with ignored start while busy");
    applyStimulus(2'b10, 8'd255, 8'd255, 17'h0_FE01);
    checkOutput(4);

    $display("[TB] start in WRITE ignored, accepted in next IDLE");
    applyStimulus(2'b00, 8'd255, 8'd255, model(2'b00, 8'd255, 8'd255));
    checkOutput(3);
    applyStimulus(2'b01, 8'd10, 8'd3, model(2'b01, 8'd10, 8'd3));
    checkOutput(0);
    applyStimulus(2'b01, 8'd0, 8'd255, model(2'b01, 8'd0, 8'd255));
    checkOutput(0);
    applyStimulus(2'b10, 8'd13, 8'd11, model(2'b10, 8'd13, 8'd11));
    checkOutput(0);
    applyStimulus(2'b10, 8'd0, 8'd37, model(2'b10, 8'd0, 8'd37));
    checkOutput(0);

    $display("[TB] divide");
    if (DIV_EN) begin
      applyStimulus(2'b11, 8'd100, 8'd7, 17'h0_020E);
      checkOutput(0);
      applyStimulus(2'b11, 8'd9, 8'd0, 17'h1_09FF);
      checkOutput(0);
      applyStimulus(2'b11, 8'd255, 8'd1, model(2'b11, 8'd255, 8'd1));
      checkOutput(0);
    end else begin
      applyStimulus(2'b11, 8'd100, 8'd7, 17'h1_0000);
      checkOutput(0);
    end

    $display("[TB] random operations");
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      applyStimulus(ro, ra, rb, model(ro, ra, rb));
      checkOutput(0);
      @(negedge clk);
    end

    $display("[TB] reset during mul");
    applyStimulus(2'b00, 8'd1, 8'd1, 17'h0_0002);
    checkOutput(0);
    applyStimulus(2'b10, 8'd3, 8'd4, model(2'b10, 8'd3, 8'd4));
    scratch = sb.pop_back();
    repeat (4) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkValue("abort_busy",   {31'b0, busy},   32'd0);
    checkValue("abort_result", {16'b0, result}, 32'd0);
    checkValue("abort_err",    {31'b0, err},    32'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) dcount++;
      @(negedge clk);
    end
    checkValue("abort_no_done", dcount, 0);
    applyStimulus(2'b00, 8'd17, 8'd25, model(2'b00, 8'd17, 8'd25));
    checkOutput(0);

    $display("[TB] reset has priority over start");
    rst = 1'b1; start = 1'b1; op = 2'b00;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checkValue("rst_over_start", {31'b0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/calc_seq_ctrl.md
CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

Interface
REQ-001 Parameter N, default 8, operand width in bits; results are 2N bits.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  operation request, sampled only while busy=0.
REQ-005 op  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-006 a  input  N  operand A, unsigned.
REQ-007 b  input  N  operand B, unsigned.
REQ-008 ld_a  output  1  load strobe for external operand-A register.
REQ-009 ld_b  output  1  load strobe for external operand-B register.
REQ-010 ld_res  output  1  load strobe for external result register.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  single-cycle completion pulse.
REQ-013 result  output  2N  last completed result, held until the next completion.
REQ-014 err  output  1  error flag for the last completed operation, held with result.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, EXEC, WRITE; IDLE->LOAD on start=1; LOAD->EXEC; EXEC->WRITE after E cycles; WRITE->IDLE.
REQ-016 With start sampled at edge k: LOAD in cycle k+1, EXEC cycles k+2..k+1+E, WRITE at k+2+E.
REQ-017 E SHALL be 1 for add/sub and N for mul/div; done is therefore high at cycle k+3 (add/sub) or k+2+N (mul/div).
REQ-018 In LOAD: ld_a=ld_b=1 for exactly one cycle; a, b and op are captured internally, and later input changes have no effect.
REQ-019 In WRITE: ld_res=1 and done=1 for exactly one cycle, and result/err update on the same edge that leaves WRITE.
REQ-020 add: result = zero-extended a+b, with the carry in bit N.
REQ-021 sub: result[N-1:0] = (a-b) mod 2^N; result[N] = 1 iff a<b; upper bits 0.
REQ-022 mul: unsigned shift-add, one partial product per EXEC cycle; result = a*b (2N bits).
REQ-023 div: unsigned restoring division, one quotient bit per EXEC cycle; result = {remainder, quotient}.
REQ-024 div with b=0: result = {a, all-ones}, err=1, with the same latency as a normal div.
REQ-025 err SHALL be 0 for all other completions.
REQ-026 start while busy=1 SHALL be ignored and not queued.
REQ-027 start asserted in the WRITE cycle is ignored; start in the first IDLE cycle after WRITE is accepted.

Reset
REQ-028 rst=1 SHALL force IDLE with busy=0, done=0, ld_a=ld_b=ld_res=0, result=0, err=0.
REQ-029 rst mid-operation SHALL abort it: no done pulse and no result update.
REQ-030 rst SHALL have priority over start in the same cycle.

Configuration
REQ-031 Macro CALC_DIV_EN defined: the divider is built and op=11 behaves per REQ-023/024.
REQ-032 CALC_DIV_EN undefined: no divider logic is built, and op=11 uses E=1 and completes with result=0, err=1.

Verification (N=8)
REQ-033 a=200, b=100, op=00, start at edge k -> done at k+3, result=0x012C, err=0, ld_res coincident with done.
REQ-034 a=5, b=7, op=01 -> result=0x01FE, err=0.
REQ-035 a=255, b=255, op=10 -> done at k+10, result=0xFE01; start pulsed at k+4 is ignored, with exactly one done.
REQ-036 a=100, b=7, op=11 (CALC_DIV_EN) -> done at k+10, result=0x020E, err=0; a=9, b=0 -> result=0x09FF, err=1.
REQ-037 op=11 without CALC_DIV_EN -> done at k+3, result=0x0000, err=1.
REQ-038 rst at k+5 during mul -> busy=0 next cycle, result=0, no done; a new add afterwards completes normally.
